gbt_frame_monitor: RTL and testbench
====================================

# gbt_frame_monitor

Receive-side link monitor sitting directly downstream of the `gbt_xu5` GBT core, in the 40 MHz frame clock domain. It checks every received 84-bit GBT frame for a fixed header byte and a strictly incrementing 8-bit sequence number. It declares link lock after a run of consecutive good frames and drops lock after a run of consecutive bad ones. While locked, it forwards the 64-bit user payload of good frames to the motor-control logic and keeps a saturating error count for diagnostics.

## Interface

Parameters:
- `LOCK_FRAMES`, 16: consecutive good frames required to enter lock (range 1..255).
- `UNLOCK_ERRORS`, 4: consecutive bad frames while locked that drop lock (range 1..255).
- `HEADER`, 8'hA5: required value of frame bits [79:72].
- `ERR_CNT_WIDTH`, 16: width of the error counter.

Ports:
- `ClkRs_ix`, input, `ckrs_t`: clock/reset bundle.
  - `.clk` is the 40 MHz frame clock and the only clock.
  - `.reset` is synchronous and active-high.
- `link_ready_i`, input, 1: GBT RX link ready from the core.
- `rx_valid_i`, input, 1: `rx_data_i` holds a new frame this cycle.
- `rx_data_i`, input, 84: received frame.
  - [83:80] IC/EC bits, ignored.
  - [79:72] header.
  - [71:64] sequence number.
  - [63:0] payload.
- `clear_i`, input, 1: synchronous clear of `error_count_o`.
- `data_o`, output, 64: forwarded payload.
- `data_valid_o`, output, 1: one-cycle strobe qualifying `data_o`.
- `locked_o`, output, 1: link locked.
- `error_count_o`, output, `ERR_CNT_WIDTH`: saturating count of bad frames seen while locked.

## Operation

Frame classification applies only to cycles with `rx_valid_i`=1. Cycles with `rx_valid_i`=0 change no state.
- *hdr_ok*: header field == `HEADER`.
- *good*: hdr_ok and sequence field == `expected` (8-bit register).
- *bad*: any other valid frame.

State machine `{UNLOCKED, SEARCH, LOCKED}`. Internal counters are `good_cnt` and `bad_cnt` (8 bits each) and `expected`.

- **UNLOCKED**
  - hdr_ok frame: `expected` <= seq+1, `good_cnt` <= 1. Go to LOCKED if `LOCK_FRAMES`==1, otherwise go to SEARCH.
  - Non-hdr_ok frame: stay in UNLOCKED.
- **SEARCH**
  - Good frame: `good_cnt`++, `expected` <= seq+1. When `good_cnt`+1 == `LOCK_FRAMES`, go to LOCKED and clear `bad_cnt`.
  - hdr_ok frame with wrong sequence: resync with `expected` <= seq+1, `good_cnt` <= 1, stay in SEARCH.
  - Non-hdr_ok frame: go to UNLOCKED, `good_cnt` <= 0.
- **LOCKED**
  - Good frame: `data_o` <= payload, `data_valid_o` pulses, `bad_cnt` <= 0, `expected` <= seq+1.
  - Bad frame: no forward, `error_count_o`++ (saturating at all-ones), `bad_cnt`++.
    - `expected` <= seq+1 if hdr_ok, otherwise `expected`+1. This absorbs a single slip.
    - When `bad_cnt`+1 == `UNLOCK_ERRORS`, go to UNLOCKED.
- **Link not ready:** `link_ready_i`=0 in any state forces UNLOCKED, clears `good_cnt`/`bad_cnt`, and suppresses `data_valid_o`. It has priority over frame processing. `error_count_o` is retained.
- **Sequence wrap:** arithmetic is modulo 256, so 8'hFF followed by 8'h00 is good.
- **Clear vs increment:** `clear_i` has priority over a simultaneous increment; the result is 0.
- **Forwarding rule:** the frame that completes the lock run is not forwarded. Only frames arriving while already LOCKED are forwarded.
- **Reset:** state UNLOCKED, all counters 0, `expected` 0. `data_o`=0, `data_valid_o`=0, `locked_o`=0, `error_count_o`=0.

## Timing

- All outputs are registered.
- `data_o`/`data_valid_o`: valid one cycle after the `rx_valid_i` cycle carrying the good frame. `data_valid_o` is high for exactly one cycle per forwarded frame. `data_o` holds its last value otherwise.
- `locked_o`: equals (state == LOCKED).
  - Rises one cycle after the `LOCK_FRAMES`-th consecutive good frame.
  - Falls one cycle after the `UNLOCK_ERRORS`-th consecutive bad frame, or one cycle after `link_ready_i` is sampled low.
- `error_count_o`: updates one cycle after the bad frame or `clear_i`.
- Back-to-back frames (`rx_valid_i` high every cycle) are supported at full rate with no stalls. There is no backpressure.
- Reset mid-operation: all outputs return to reset values on the next edge. Any frame presented in the reset cycle is dropped.

## Test plan

1. **Lock acquisition.** Reset, `link_ready_i`=1, then 16 frames with header A5 and seq 0..15 back-to-back.
   - `locked_o` rises one cycle after seq 15.
   - `data_valid_o` stays low throughout.
   - Seq 16 (payload 64'h0123_4567_89AB_CDEF) produces `data_valid_o` and that `data_o` one cycle later.
2. **Slip tolerance.** While locked, send seq 20, 22, 23.
   - Seq 22 is not forwarded and `error_count_o`=1.
   - Seq 23 is forwarded.
   - `locked_o` stays 1.
3. **Lock loss.** While locked, send 4 consecutive frames with header 8'h00.
   - `error_count_o`=4.
   - `locked_o` falls one cycle after the 4th frame.
   - No `data_valid_o` pulse.
4. **Sequence wrap.** While locked, send seq FE, FF, 00, 01.
   - All four are forwarded and `error_count_o` is unchanged.
   - `rx_valid_i` gaps between frames cause no state change.
5. **Link drop and clear.**
   - Drop `link_ready_i` while locked with `error_count_o`=3: `locked_o`=0 next cycle and the count stays 3.
   - Assert `clear_i` in the same cycle as a bad locked frame: `error_count_o`=0.
6. **Saturation.** With `ERR_CNT_WIDTH`=4 and `UNLOCK_ERRORS`=255, send 20 bad frames while locked.
   - `error_count_o` stops at 4'hF.
   - `locked_o` stays 1.

Source files
------------

// File: rtl/gbt_frame_monitor.sv
// Receive-side GBT frame monitor: header/sequence checking, lock tracking,
// payload forwarding while locked and a saturating diagnostic error count.
package gbt_frame_monitor_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module gbt_frame_monitor
  import gbt_frame_monitor_pkg::*;
#(
  parameter int         LOCK_FRAMES   = 16,
  parameter int         UNLOCK_ERRORS = 4,
  parameter logic [7:0] HEADER        = 8'hA5,
  parameter int         ERR_CNT_WIDTH = 16
) (
  input  ckrs_t                     ClkRs_ix,
  input  logic                      link_ready_i,
  input  logic                      rx_valid_i,
  input  logic [83:0]               rx_data_i,
  input  logic                      clear_i,
  output logic [63:0]               data_o,
  output logic                      data_valid_o,
  output logic                      locked_o,
  output logic [ERR_CNT_WIDTH-1:0]  error_count_o
);

  localparam logic [7:0]               LOCK_FRAMES_C   = 8'(LOCK_FRAMES);
  localparam logic [7:0]               UNLOCK_ERRORS_C = 8'(UNLOCK_ERRORS);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX_C       = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE_C       = ERR_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEARCH   = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] good_cnt_r;
  logic [7:0] bad_cnt_r;
  logic [7:0] expected_r;

  logic [7:0] seq_s;
  logic [7:0] seq_next_s;
  logic       hdr_ok_s;
  logic       good_s;
  logic       err_inc_s;

  assign seq_s      = rx_data_i[71:64];
  assign seq_next_s = seq_s + 8'd1;
  assign hdr_ok_s   = (rx_data_i[79:72] == HEADER);
  assign good_s     = hdr_ok_s && (seq_s == expected_r);
  assign err_inc_s  = link_ready_i && rx_valid_i && (state_r == LOCKED) && !good_s &&
                      (error_count_o != ERR_MAX_C);

  // Lock state machine, frame forwarding and error counter
  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      state_r       <= UNLOCKED;
      good_cnt_r    <= 8'd0;
      bad_cnt_r     <= 8'd0;
      expected_r    <= 8'd0;
      data_o        <= 64'd0;
      data_valid_o  <= 1'b0;
      locked_o      <= 1'b0;
      error_count_o <= '0;
    end else begin
      data_valid_o <= 1'b0;

      // clear wins over a same-cycle increment
      if (clear_i) begin
        error_count_o <= '0;
      end else if (err_inc_s) begin
        error_count_o <= error_count_o + ERR_ONE_C;
      end

      if (!link_ready_i) begin
        state_r    <= UNLOCKED;
        locked_o   <= 1'b0;
        good_cnt_r <= 8'd0;
        bad_cnt_r  <= 8'd0;
      end else if (rx_valid_i) begin
        case (state_r)
          UNLOCKED: begin
            if (hdr_ok_s) begin
              expected_r <= seq_next_s;
              good_cnt_r <= 8'd1;
              bad_cnt_r  <= 8'd0;
              if (LOCK_FRAMES_C == 8'd1) begin
                state_r  <= LOCKED;
                locked_o <= 1'b1;
              end else begin
                state_r <= SEARCH;
              end
            end
          end
          SEARCH: begin
            if (good_s) begin
              good_cnt_r <= good_cnt_r + 8'd1;
              expected_r <= seq_next_s;
              if (good_cnt_r + 8'd1 == LOCK_FRAMES_C) begin
                state_r   <= LOCKED;
                locked_o  <= 1'b1;
                bad_cnt_r <= 8'd0;
              end
            end else if (hdr_ok_s) begin
              expected_r <= seq_next_s;
              good_cnt_r <= 8'd1;
            end else begin
              state_r    <= UNLOCKED;
              good_cnt_r <= 8'd0;
            end
          end
          LOCKED: begin
            if (good_s) begin
              data_o       <= rx_data_i[63:0];
              data_valid_o <= 1'b1;
              bad_cnt_r    <= 8'd0;
              expected_r   <= seq_next_s;
            end else begin
              bad_cnt_r  <= bad_cnt_r + 8'd1;
              // a header-valid frame resyncs, otherwise assume one slot was lost
              expected_r <= hdr_ok_s ? seq_next_s : (expected_r + 8'd1);
              if (bad_cnt_r + 8'd1 == UNLOCK_ERRORS_C) begin
                state_r    <= UNLOCKED;
                locked_o   <= 1'b0;
                good_cnt_r <= 8'd0;
                bad_cnt_r  <= 8'd0;
              end
            end
          end
          default: begin
            state_r    <= UNLOCKED;
            locked_o   <= 1'b0;
            good_cnt_r <= 8'd0;
            bad_cnt_r  <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gbt_frame_monitor.sv
// Bench for gbt_frame_monitor: two instances (default and 4-bit/255-error build)
// driven with identical stimulus and checked against a rule-level model.
module tb_gbt_frame_monitor;
  import gbt_frame_monitor_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ckrs_t ckrs;
  assign ckrs = {clk, reset};
  always #12 clk = ~clk;

  logic        link_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [83:0] rx_data = 84'd0;
  logic        clear = 1'b0;

  logic [63:0] data0, data1;
  logic        dv0, dv1, lk0, lk1;
  logic [15:0] err0;
  logic [3:0]  err1;

  gbt_frame_monitor u_dut0 (
    .ClkRs_ix(ckrs), .link_ready_i(link_ready), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .clear_i(clear), .data_o(data0), .data_valid_o(dv0), .locked_o(lk0), .error_count_o(err0));

  gbt_frame_monitor #(.UNLOCK_ERRORS(255), .ERR_CNT_WIDTH(4)) u_dut1 (
    .ClkRs_ix(ckrs), .link_ready_i(link_ready), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .clear_i(clear), .data_o(data1), .data_valid_o(dv1), .locked_o(lk1), .error_count_o(err1));

  logic [81:0] got [2];
  assign got[0] = {dv0, lk0, data0, err0};
  assign got[1] = {dv1, lk1, data1, 12'd0, err1};

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0=unlocked, 1=searching, 2=locked
  int          lf [2] = '{16, 16};
  int          ue [2] = '{4, 255};
  int          emax [2] = '{65535, 15};
  int          m_mode [2], m_good [2], m_bad [2], m_exp [2], m_err [2];
  logic        m_dv [2], m_lk [2];
  logic [63:0] m_data [2];

  function automatic logic [81:0] mvec(int k);
    return {m_dv[k], m_lk[k], m_data[k], 16'(m_err[k])};
  endfunction

  task automatic model_step();
    int hdr, seq;
    bit hok, gf, inc;
    hdr = int'(rx_data[79:72]);
    seq = int'(rx_data[71:64]);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_mode[k] = 0; m_good[k] = 0; m_bad[k] = 0; m_exp[k] = 0; m_err[k] = 0;
        m_dv[k] = 1'b0; m_lk[k] = 1'b0; m_data[k] = 64'd0;
      end else begin
        inc = 1'b0;
        m_dv[k] = 1'b0;
        if (!link_ready) begin
          m_mode[k] = 0; m_good[k] = 0; m_bad[k] = 0;
        end else if (rx_valid) begin
          hok = (hdr == 'hA5);
          gf = hok && (seq == m_exp[k]);
          if (m_mode[k] == 0) begin
            if (hok) begin
              m_exp[k] = (seq + 1) % 256; m_good[k] = 1; m_bad[k] = 0;
              m_mode[k] = (lf[k] == 1) ? 2 : 1;
            end
          end else if (m_mode[k] == 1) begin
            if (gf) begin
              m_good[k]++; m_exp[k] = (seq + 1) % 256;
              if (m_good[k] == lf[k]) begin m_mode[k] = 2; m_bad[k] = 0; end
            end else if (hok) begin
              m_exp[k] = (seq + 1) % 256; m_good[k] = 1;
            end else begin
              m_mode[k] = 0; m_good[k] = 0;
            end
          end else begin
            if (gf) begin
              m_data[k] = rx_data[63:0]; m_dv[k] = 1'b1; m_bad[k] = 0;
              m_exp[k] = (seq + 1) % 256;
            end else begin
              inc = 1'b1; m_bad[k]++;
              m_exp[k] = hok ? (seq + 1) % 256 : (m_exp[k] + 1) % 256;
              if (m_bad[k] == ue[k]) begin m_mode[k] = 0; m_good[k] = 0; m_bad[k] = 0; end
            end
          end
        end
        if (clear) m_err[k] = 0;
        else if (inc && m_err[k] < emax[k]) m_err[k]++;
        m_lk[k] = (m_mode[k] == 2);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [7:0] hdr, input logic [7:0] seq, input logic [63:0] pl);
    rx_valid = 1'b1;
    rx_data = {4'($urandom), hdr, seq, pl};
    tick();
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data = {20'($urandom), 32'($urandom), 32'($urandom)};
    repeat (n) tick();
  endtask

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; link_ready = 1'b1;
    send(8'hA5, 8'h00, rnd64());
    send(8'hA5, 8'h01, rnd64());
    checks++;
    if ({dv0, lk0, err0, data0} !== 82'd0) begin
      failures++; $display("FAIL reset_state dut=%h required=0", {dv0, lk0, err0, data0});
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k] !== mvec(k)) begin
        failures++; $display("FAIL reset_model[%0d] dut=%h model=%h", k, got[k], mvec(k));
      end
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_lock_acq();
    link_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      send(8'hA5, 8'(s), rnd64());
      checks++;
      if (dv0 !== 1'b0 || lk0 !== (s == 15)) begin
        failures++; $display("FAIL lock_acq seq=%0d dv=%b locked=%b required dv=0 locked=%b", s, dv0, lk0, s == 15);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got[k] !== mvec(k)) begin
          failures++; $display("FAIL lock_acq_model[%0d] dut=%h model=%h", k, got[k], mvec(k));
        end
      end
    end
    send(8'hA5, 8'd16, 64'h0123_4567_89AB_CDEF);
    checks++;
    if (dv0 !== 1'b1 || data0 !== 64'h0123_4567_89AB_CDEF) begin
      failures++; $display("FAIL first_forward dv=%b data=%h required 1/0123456789abcdef", dv0, data0);
    end
  endtask

  task automatic test_slip();
    for (int s = 17; s <= 20; s++) send(8'hA5, 8'(s), rnd64());
    send(8'hA5, 8'd22, rnd64());
    checks++;
    if (dv0 !== 1'b0 || err0 !== 16'd1) begin
      failures++; $display("FAIL slip_bad dv=%b err=%0d required dv=0 err=1", dv0, err0);
    end
    send(8'hA5, 8'd23, 64'hDEAD_BEEF_0000_0023);
    checks++;
    if (dv0 !== 1'b1 || data0 !== 64'hDEAD_BEEF_0000_0023 || lk0 !== 1'b1) begin
      failures++; $display("FAIL slip_recover dv=%b data=%h locked=%b required 1/deadbeef00000023/1", dv0, data0, lk0);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k] !== mvec(k)) begin
        failures++; $display("FAIL slip_model[%0d] dut=%h model=%h", k, got[k], mvec(k));
      end
    end
  endtask

  task automatic test_lock_loss();
    clear = 1'b1; idle(1); clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'h00, 8'($urandom), rnd64());
      checks++;
      if (dv0 !== 1'b0 || lk0 !== (i != 3) || err0 !== 16'(i + 1)) begin
        failures++; $display("FAIL lock_loss i=%0d dv=%b locked=%b err=%0d required 0/%b/%0d", i, dv0, lk0, err0, i != 3, i + 1);
      end
    end
    checks++;
    if (lk1 !== 1'b1 || err1 !== 4'd4) begin
      failures++; $display("FAIL lock_loss_ue255 locked=%b err=%0d required 1/4", lk1, err1);
    end
  endtask

  task automatic test_wrap();
    int e0;
    logic [63:0] pl;
    logic [7:0] wseq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int s = 8'hEE; s <= 8'hFD; s++) send(8'hA5, 8'(s), rnd64());
    checks++;
    if (lk0 !== 1'b1) begin
      failures++; $display("FAIL relock locked=%b required 1", lk0);
    end
    e0 = int'(err0);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      pl = rnd64();
      send(8'hA5, wseq[i], pl);
      checks++;
      if (dv0 !== 1'b1 || data0 !== pl || int'(err0) != e0) begin
        failures++; $display("FAIL wrap seq=%h dv=%b data=%h err=%0d required 1/%h/%0d", wseq[i], dv0, data0, err0, pl, e0);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got[k] !== mvec(k)) begin
          failures++; $display("FAIL wrap_model[%0d] dut=%h model=%h", k, got[k], mvec(k));
        end
      end
    end
    idle(1);
  endtask

  task automatic test_link_drop_clear();
    int base;
    clear = 1'b1; idle(1); clear = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h3C, 8'($urandom), rnd64());
    checks++;
    if (err0 !== 16'd3 || lk0 !== 1'b1) begin
      failures++; $display("FAIL pre_drop err=%0d locked=%b required 3/1", err0, lk0);
    end
    link_ready = 1'b0;
    send(8'hA5, 8'h05, rnd64());
    checks++;
    if (lk0 !== 1'b0 || err0 !== 16'd3 || dv0 !== 1'b0) begin
      failures++; $display("FAIL link_drop locked=%b err=%0d dv=%b required 0/3/0", lk0, err0, dv0);
    end
    link_ready = 1'b1;
    base = $urandom_range(0, 255);
    for (int i = 0; i < 16; i++) send(8'hA5, 8'((base + i) % 256), rnd64());
    checks++;
    if (lk0 !== 1'b1) begin
      failures++; $display("FAIL relock_after_drop locked=%b required 1", lk0);
    end
    clear = 1'b1;
    send(8'h00, 8'($urandom), rnd64());
    clear = 1'b0;
    checks++;
    if (err0 !== 16'd0 || err1 !== 4'd0 || dv0 !== 1'b0) begin
      failures++; $display("FAIL clear_priority err0=%0d err1=%0d dv=%b required 0/0/0", err0, err1, dv0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      send(8'h5A, 8'($urandom), rnd64());
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got[k] !== mvec(k)) begin
          failures++; $display("FAIL sat_model[%0d] i=%0d dut=%h model=%h", k, i, got[k], mvec(k));
        end
      end
    end
    checks++;
    if (err1 !== 4'hF || lk1 !== 1'b1) begin
      failures++; $display("FAIL saturation err=%h locked=%b required f/1", err1, lk1);
    end
  endtask

  task automatic test_random();
    logic [7:0] nseq = 8'd0;
    logic [7:0] hdr, seq;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      link_ready = ($urandom_range(0, 99) != 0);
      clear = ($urandom_range(0, 59) == 0);
      hdr = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'hA5;
      seq = ($urandom_range(0, 11) == 0) ? 8'($urandom) : nseq;
      nseq = seq + 8'd1;
      if ($urandom_range(0, 3) != 0) send(hdr, seq, rnd64());
      else idle(1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got[k] !== mvec(k)) begin
          failures++; $display("FAIL random_model[%0d] cyc=%0d dut=%h model=%h", k, c, got[k], mvec(k));
        end
      end
    end
    reset = 1'b0; clear = 1'b0; link_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_acq();
    test_slip();
    test_lock_loss();
    test_wrap();
    test_link_drop_clear();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
